// File: rtl/mbp_lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: op encodings,
// FSM states, access sizes and lane/alignment helpers.
package mbp_lsu_pkg;

  typedef enum logic [2:0] {
    OP_LW  = 3'd0,
    OP_LH  = 3'd1,
    OP_LHU = 3'd2,
    OP_LB  = 3'd3,
    OP_LBU = 3'd4,
    OP_SW  = 3'd5,
    OP_SH  = 3'd6,
    OP_SB  = 3'd7
  } lsu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RMW_READ  = 2'd1,
    ST_RMW_WRITE = 2'd2
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } lsu_size_e;

  localparam int unsigned LANE_W    = 8;
  localparam int unsigned NUM_LANES = 4;

  // Access size implied by an op.
  function automatic lsu_size_e op_size(input lsu_op_e op);
    lsu_size_e sz;
    case (op)
      OP_LW, OP_SW:         sz = SZ_WORD;
      OP_LH, OP_LHU, OP_SH: sz = SZ_HALF;
      OP_LB, OP_LBU, OP_SB: sz = SZ_BYTE;
      default:              sz = SZ_WORD;
    endcase
    return sz;
  endfunction

  // Stores write memory; everything else is a load.
  function automatic logic op_is_store(input lsu_op_e op);
    logic st;
    case (op)
      OP_SW, OP_SH, OP_SB: st = 1'b1;
      default:             st = 1'b0;
    endcase
    return st;
  endfunction

  // Only LB and LH sign-extend.
  function automatic logic op_is_signed(input lsu_op_e op);
    logic sg;
    case (op)
      OP_LB, OP_LH: sg = 1'b1;
      default:      sg = 1'b0;
    endcase
    return sg;
  endfunction

  // Word accesses need addr[1:0]==0, halfword accesses need addr[0]==0.
  function automatic logic addr_misaligned(input lsu_op_e op, input logic [1:0] lo);
    logic bad;
    case (op_size(op))
      SZ_WORD: bad = (lo != 2'b00);
      SZ_HALF: bad = lo[0];
      SZ_BYTE: bad = 1'b0;
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

  // Bit offset of the addressed byte/half inside the 32-bit word.
  function automatic logic [4:0] lane_shift(input logic [1:0] lane, input lsu_size_e sz,
                                            input logic little_end);
    logic [4:0] sh;
    case (sz)
      SZ_BYTE: sh = little_end ? {lane, 3'b000} : {~lane, 3'b000};
      SZ_HALF: sh = little_end ? {lane[1], 4'b0000} : {~lane[1], 4'b0000};
      SZ_WORD: sh = 5'd0;
      default: sh = 5'd0;
    endcase
    return sh;
  endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Combinational byte/half lane handling: extracts and extends load data from
// a memory word, and merges store data into a word for read-modify-write.
module lsu_byte_lane
  import mbp_lsu_pkg::*;
#(
  parameter bit LITTLE_END = 1'b1
) (
  input  logic [31:0] rd_word,
  input  logic [1:0]  lane,
  input  lsu_size_e   size,
  input  logic        sign_ext,
  input  logic [31:0] wdata,
  output logic [31:0] ld_ext,
  output logic [31:0] merged
);

  logic [4:0]  shift_s;
  logic [31:0] aligned_s;
  logic [31:0] mask_s;

  // Right-justify the selected lane(s) and extend to a full word.
  always_comb begin
    shift_s   = lane_shift(lane, size, LITTLE_END);
    aligned_s = rd_word >> shift_s;
    case (size)
      SZ_BYTE: begin
        if (sign_ext) begin
          ld_ext = {{24{aligned_s[7]}}, aligned_s[7:0]};
        end else begin
          ld_ext = {24'd0, aligned_s[7:0]};
        end
      end
      SZ_HALF: begin
        if (sign_ext) begin
          ld_ext = {{16{aligned_s[15]}}, aligned_s[15:0]};
        end else begin
          ld_ext = {16'd0, aligned_s[15:0]};
        end
      end
      SZ_WORD: ld_ext = aligned_s;
      default: ld_ext = aligned_s;
    endcase
  end

  // Replace the addressed lane(s) of the read word with the low store bytes.
  always_comb begin
    case (size)
      SZ_BYTE: mask_s = 32'h0000_00FF;
      SZ_HALF: mask_s = 32'h0000_FFFF;
      SZ_WORD: mask_s = 32'hFFFF_FFFF;
      default: mask_s = 32'hFFFF_FFFF;
    endcase
    merged = (rd_word & ~(mask_s << shift_s)) | ((wdata & mask_s) << shift_s);
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit in front of the unified memory data port.
// Loads and SW complete in a single cycle against the combinational read
// port; SB/SH are read-modify-write sequences that stall the pipe.
module mem_stage_lsu
  import mbp_lsu_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter bit LITTLE_END = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [4:0]        req_rd,
  output logic [ADDR_W-1:0] data_addr,
  output logic [DATA_W-1:0] data_write_data,
  output logic              data_sig_mem_write,
  input  logic [DATA_W-1:0] data_read_data,
  output logic              ld_valid,
  output logic [DATA_W-1:0] ld_data,
  output logic [4:0]        ld_rd,
  output logic              stall,
  output logic              addr_err
);

  lsu_state_e        state_r;
  logic [ADDR_W-1:0] addr_r;
  logic [1:0]        lane_r;
  lsu_size_e         size_r;
  logic [DATA_W-1:0] wdata_r;
  logic [DATA_W-1:0] merge_r;
  logic              ld_valid_r;
  logic [DATA_W-1:0] ld_data_r;
  logic [4:0]        ld_rd_r;
  logic              addr_err_r;
  logic              stall_r;

  lsu_op_e           op_s;
  lsu_size_e         size_s;
  logic              misalign_s;
  logic              is_store_s;
  logic              sign_s;
  logic              accept_s;
  logic [ADDR_W-1:0] req_word_addr_s;

  logic [1:0]        lane_sel_s;
  lsu_size_e         size_sel_s;
  logic              sign_sel_s;
  logic [DATA_W-1:0] wdata_sel_s;
  logic [DATA_W-1:0] ld_ext_s;
  logic [DATA_W-1:0] merged_s;

  logic [ADDR_W-1:0] data_addr_s;
  logic [DATA_W-1:0] data_wdata_s;
  logic              data_we_s;

  // Decode the incoming request.
  always_comb begin
    op_s            = lsu_op_e'(req_op);
    size_s          = op_size(op_s);
    misalign_s      = addr_misaligned(op_s, req_addr[1:0]);
    is_store_s      = op_is_store(op_s);
    sign_s          = op_is_signed(op_s);
    accept_s        = req_valid & (state_r == ST_IDLE);
    req_word_addr_s = {req_addr[ADDR_W-1:2], 2'b00};
  end

  // In IDLE the lane logic serves the live request; during RMW it serves the latched store.
  always_comb begin
    if (state_r == ST_IDLE) begin
      lane_sel_s  = req_addr[1:0];
      size_sel_s  = size_s;
      sign_sel_s  = sign_s;
      wdata_sel_s = req_wdata;
    end else begin
      lane_sel_s  = lane_r;
      size_sel_s  = size_r;
      sign_sel_s  = 1'b0;
      wdata_sel_s = wdata_r;
    end
  end

  lsu_byte_lane #(
    .LITTLE_END (LITTLE_END)
  ) u_lane (
    .rd_word  (data_read_data),
    .lane     (lane_sel_s),
    .size     (size_sel_s),
    .sign_ext (sign_sel_s),
    .wdata    (wdata_sel_s),
    .ld_ext   (ld_ext_s),
    .merged   (merged_s)
  );

  // Memory port drive; gated by rst_n so the strobe drops the instant reset asserts.
  always_comb begin
    data_addr_s  = '0;
    data_wdata_s = '0;
    data_we_s    = 1'b0;
    if (!rst_n) begin
      data_addr_s  = '0;
      data_wdata_s = '0;
      data_we_s    = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_valid) begin
            data_addr_s = req_word_addr_s;
            if ((op_s == OP_SW) && !misalign_s) begin
              data_wdata_s = req_wdata;
              data_we_s    = 1'b1;
            end else begin
              data_wdata_s = '0;
              data_we_s    = 1'b0;
            end
          end else begin
            data_addr_s = '0;
          end
        end
        ST_RMW_READ: begin
          data_addr_s = addr_r;
        end
        ST_RMW_WRITE: begin
          data_addr_s  = addr_r;
          data_wdata_s = merge_r;
          data_we_s    = 1'b1;
        end
        default: begin
          data_addr_s = '0;
        end
      endcase
    end
  end

  // Control FSM with load return, error pulse and RMW latches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      addr_r     <= '0;
      lane_r     <= 2'b00;
      size_r     <= SZ_BYTE;
      wdata_r    <= '0;
      merge_r    <= '0;
      ld_valid_r <= 1'b0;
      ld_data_r  <= '0;
      ld_rd_r    <= 5'd0;
      addr_err_r <= 1'b0;
      stall_r    <= 1'b0;
    end else begin
      ld_valid_r <= 1'b0;
      addr_err_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            if (misalign_s) begin
              addr_err_r <= 1'b1;
            end else if (!is_store_s) begin
              ld_valid_r <= 1'b1;
              ld_data_r  <= ld_ext_s;
              ld_rd_r    <= req_rd;
            end else if (op_s != OP_SW) begin
              addr_r  <= req_word_addr_s;
              lane_r  <= req_addr[1:0];
              size_r  <= size_s;
              wdata_r <= req_wdata;
              stall_r <= 1'b1;
              state_r <= ST_RMW_READ;
            end else begin
              state_r <= ST_IDLE;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_RMW_READ: begin
          merge_r <= merged_s;
          state_r <= ST_RMW_WRITE;
        end
        ST_RMW_WRITE: begin
          stall_r <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          stall_r <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready          = ~stall_r;
  assign stall              = stall_r;
  assign data_addr          = data_addr_s;
  assign data_write_data    = data_wdata_s;
  assign data_sig_mem_write = data_we_s;
  assign ld_valid           = ld_valid_r;
  assign ld_data            = ld_data_r;
  assign ld_rd              = ld_rd_r;
  assign addr_err           = addr_err_r;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: a small word memory models the
// unified MEMORY block, and a byte-level reference model predicts results.
module tb_mem_stage_lsu;
  import mbp_lsu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic [31:0] data_addr;
  logic [31:0] data_write_data;
  logic        data_sig_mem_write;
  logic [31:0] data_read_data;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic [4:0]  ld_rd;
  logic        stall;
  logic        addr_err;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] env_mem [0:63];
  logic [31:0] ref_mem [0:63];
  logic        tb_wr_en;
  logic [5:0]  tb_wr_idx;
  logic [31:0] tb_wr_val;

  mem_stage_lsu dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .req_valid          (req_valid),
    .req_ready          (req_ready),
    .req_op             (req_op),
    .req_addr           (req_addr),
    .req_wdata          (req_wdata),
    .req_rd             (req_rd),
    .data_addr          (data_addr),
    .data_write_data    (data_write_data),
    .data_sig_mem_write (data_sig_mem_write),
    .data_read_data     (data_read_data),
    .ld_valid           (ld_valid),
    .ld_data            (ld_data),
    .ld_rd              (ld_rd),
    .stall              (stall),
    .addr_err           (addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory stand-in: combinational read, write on the rising edge.
  assign data_read_data = env_mem[data_addr[7:2]];
  always @(posedge clk) begin
    if (tb_wr_en) env_mem[tb_wr_idx] <= tb_wr_val;
    else if (data_sig_mem_write) env_mem[data_addr[7:2]] <= data_write_data;
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%08h exp=%08h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] set_byte(input logic [31:0] w, input int k, input logic [31:0] b);
    return (w & ~(32'hFF << (8 * k))) | ((b & 32'hFF) << (8 * k));
  endfunction

  // Issue one request at posedge+1; returns at posedge+1 after it completes.
  task automatic do_req(input logic [2:0] op, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [4:0] rd);
    int          idx;
    int          off;
    logic        mis;
    logic        is_st;
    logic        rmw;
    logic [31:0] w;
    logic [31:0] piece;
    logic [31:0] exp_ld;
    logic [31:0] new_w;
    idx   = int'(addr[7:2]);
    off   = int'(addr[1:0]);
    w     = ref_mem[idx];
    is_st = (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
    if ((op == OP_LW) || (op == OP_SW)) mis = (off != 0);
    else if ((op == OP_LH) || (op == OP_LHU) || (op == OP_SH)) mis = ((off % 2) != 0);
    else mis = 1'b0;
    rmw = ((op == OP_SH) || (op == OP_SB)) && !mis;
    exp_ld = w;
    if ((op == OP_LH) || (op == OP_LHU)) begin
      piece  = (w >> (8 * off)) & 32'hFFFF;
      exp_ld = ((op == OP_LH) && (piece >= 32'h8000)) ? (piece | 32'hFFFF_0000) : piece;
    end else if ((op == OP_LB) || (op == OP_LBU)) begin
      piece  = (w >> (8 * off)) & 32'hFF;
      exp_ld = ((op == OP_LB) && (piece >= 32'h80)) ? (piece | 32'hFFFF_FF00) : piece;
    end
    new_w = w;
    if (op == OP_SW) new_w = wd;
    else if (op == OP_SH) begin
      new_w = set_byte(new_w, off, wd);
      new_w = set_byte(new_w, off + 1, wd >> 8);
    end else if (op == OP_SB) new_w = set_byte(new_w, off, wd);

    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd; req_rd = rd;
    #2;
    chk_eq("accept_ready", 32'(req_ready), 32'd1);
    chk_eq("accept_addr", data_addr, {addr[31:2], 2'b00});
    chk_eq("accept_strobe", 32'(data_sig_mem_write), 32'((op == OP_SW) && !mis));
    if ((op == OP_SW) && !mis) chk_eq("sw_wdata", data_write_data, wd);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk_eq("ld_valid", 32'(ld_valid), 32'(!is_st && !mis));
    if (!is_st && !mis) begin
      chk_eq("ld_data", ld_data, exp_ld);
      chk_eq("ld_rd", 32'(ld_rd), 32'(rd));
    end
    chk_eq("addr_err", 32'(addr_err), 32'(mis));
    chk_eq("stall", 32'(stall), 32'(rmw));
    if (is_st && !mis) ref_mem[idx] = new_w;
    if (rmw) begin
      chk_eq("rmw_rd_ready", 32'(req_ready), 32'd0);
      chk_eq("rmw_rd_strobe", 32'(data_sig_mem_write), 32'd0);
      chk_eq("rmw_rd_addr", data_addr, {addr[31:2], 2'b00});
      @(posedge clk); #1;
      chk_eq("rmw_wr_stall", 32'(stall), 32'd1);
      chk_eq("rmw_wr_strobe", 32'(data_sig_mem_write), 32'd1);
      chk_eq("rmw_wr_addr", data_addr, {addr[31:2], 2'b00});
      chk_eq("rmw_wr_data", data_write_data, new_w);
      @(posedge clk); #1;
      chk_eq("rmw_done_stall", 32'(stall), 32'd0);
      chk_eq("rmw_done_ready", 32'(req_ready), 32'd1);
      chk_eq("rmw_done_strobe", 32'(data_sig_mem_write), 32'd0);
    end
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] raddr;
    logic [31:0] rval;
    rst_n = 1'b0; req_valid = 1'b0; req_op = 3'd0; req_addr = 32'd0;
    req_wdata = 32'd0; req_rd = 5'd0;
    tb_wr_en = 1'b0; tb_wr_idx = 6'd0; tb_wr_val = 32'd0;
    #3;
    chk_eq("rst_ready", 32'(req_ready), 32'd1);
    chk_eq("rst_stall", 32'(stall), 32'd0);
    chk_eq("rst_strobe", 32'(data_sig_mem_write), 32'd0);
    chk_eq("rst_ld_valid", 32'(ld_valid), 32'd0);
    chk_eq("rst_ld_data", ld_data, 32'd0);
    chk_eq("rst_addr_err", 32'(addr_err), 32'd0);
    chk_eq("rst_data_addr", data_addr, 32'd0);

    // Fill both memories with the same random contents while in reset.
    for (int i = 0; i < 64; i++) begin
      rval = $urandom;
      tb_wr_en = 1'b1; tb_wr_idx = 6'(i); tb_wr_val = rval;
      ref_mem[i] = rval;
      @(posedge clk); #1;
    end
    tb_wr_en = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: SW then LW
    do_req(OP_SW, 32'h1000, 32'hDEAD_BEEF, 5'd0);
    do_req(OP_LW, 32'h1000, 32'd0, 5'd3);
    chk_eq("t1_lw", ld_data, 32'hDEAD_BEEF);
    // 2: SB into byte 1
    do_req(OP_SB, 32'h1001, 32'h0000_0012, 5'd0);
    do_req(OP_LW, 32'h1000, 32'd0, 5'd4);
    chk_eq("t2_lw", ld_data, 32'hDEAD_12EF);
    do_req(OP_LB, 32'h1001, 32'd0, 5'd5);
    chk_eq("t2_lb", ld_data, 32'h0000_0012);
    // 3: SH into upper half, signed and unsigned halfword loads
    do_req(OP_SH, 32'h1002, 32'h0000_8001, 5'd0);
    do_req(OP_LW, 32'h1000, 32'd0, 5'd6);
    chk_eq("t3_lw", ld_data, 32'h8001_12EF);
    do_req(OP_LH, 32'h1002, 32'd0, 5'd7);
    chk_eq("t3_lh", ld_data, 32'hFFFF_8001);
    do_req(OP_LHU, 32'h1002, 32'd0, 5'd8);
    chk_eq("t3_lhu", ld_data, 32'h0000_8001);
    // 4: misaligned accesses leave memory untouched
    do_req(OP_LW, 32'h1002, 32'd0, 5'd9);
    do_req(OP_SH, 32'h1003, 32'h0000_FFFF, 5'd0);
    do_req(OP_LW, 32'h1000, 32'd0, 5'd10);
    chk_eq("t4_lw", ld_data, 32'h8001_12EF);
    // 5: reset asserted during the RMW write cycle drops the store
    req_valid = 1'b1; req_op = OP_SB; req_addr = 32'h1004; req_wdata = 32'h55; req_rd = 5'd0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk_eq("t5_strobe_pre", 32'(data_sig_mem_write), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_eq("t5_strobe_rst", 32'(data_sig_mem_write), 32'd0);
    chk_eq("t5_ready_rst", 32'(req_ready), 32'd1);
    chk_eq("t5_stall_rst", 32'(stall), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_req(OP_LW, 32'h1004, 32'd0, 5'd11);
    // 6: back-to-back SW, SW, LW (distinct, then aliased)
    do_req(OP_SW, 32'h1010, 32'h1111_2222, 5'd0);
    do_req(OP_SW, 32'h1014, 32'h3333_4444, 5'd0);
    do_req(OP_LW, 32'h1014, 32'd0, 5'd12);
    chk_eq("t6_lw", ld_data, 32'h3333_4444);
    do_req(OP_SW, 32'h1018, 32'hAAAA_0001, 5'd0);
    do_req(OP_SW, 32'h1018, 32'hBBBB_0002, 5'd0);
    do_req(OP_LW, 32'h1018, 32'd0, 5'd13);
    chk_eq("t6_alias", ld_data, 32'hBBBB_0002);

    // Random traffic, mostly aligned, with occasional idle cycles.
    for (int n = 0; n < 400; n++) begin
      rop   = 3'($urandom_range(0, 7));
      raddr = 32'h1000 + 32'($urandom_range(0, 63) * 4) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) begin
        if ((rop == OP_LW) || (rop == OP_SW)) raddr[1:0] = 2'b00;
        else if ((rop == OP_LH) || (rop == OP_LHU) || (rop == OP_SH)) raddr[0] = 1'b0;
      end
      do_req(rop, raddr, $urandom, 5'($urandom_range(0, 31)));
      if ($urandom_range(0, 4) == 0) begin
        #2;
        chk_eq("idle_strobe", 32'(data_sig_mem_write), 32'd0);
        @(posedge clk); #1;
        chk_eq("idle_ld_valid", 32'(ld_valid), 32'd0);
      end
    end

    for (int i = 0; i < 64; i++) begin
      chk_eq($sformatf("mem_%0d", i), env_mem[i], ref_mem[i]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
